mem_wb_stage: RTL
=================

# mem_wb_stage

Memory-access and writeback stage of the five-stage RV32I pipeline. Takes the executed instruction, its control word and its ALU/compare results from EX, and performs the data-memory handshake for loads and stores. It then selects the register-file write value and drives the regfile write port in the decode stage (`rd_wb`, `load_regfile_wb`, `regfilemux_out_wb`). It is the producer end of the regfile write interface that the decode stage consumes.

## Interface
Parameters: none. Shared types come from `rv32i_types`.

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  reset: synchronous, active-low (asserted when 0)
- `valid_ex`  in  1  EX presents an instruction this cycle
- `ctrl_ex`  in  `rv32i_control_word`  control word (`opcode`, `load_regfile`, `data_read`, `data_write`, `regfilemux_sel`)
- `funct3_ex`  in  3  load/store width
- `rd_ex`  in  5  destination register
- `alu_out_ex`  in  32  ALU result / effective address
- `br_en_ex`  in  1  compare result
- `rs2_out_ex`  in  32  store data
- `u_imm_ex`  in  32  U-immediate
- `pc_ex`  in  32  instruction PC
- `data_addr`  out  32  word-aligned address, `{alu_out[31:2],2'b00}`
- `data_wdata`  out  32  lane-shifted store data
- `data_mbe`  out  4  byte enables
- `data_read` / `data_write`  out  1  memory request strobes
- `data_rdata`  in  32  read data
- `data_resp`  in  1  memory completion, one-cycle pulse
- `stall_mem`  out  1  upstream must hold its instruction
- `rd_wb`  out  5  regfile destination
- `load_regfile_wb`  out  1  regfile write enable, one cycle per instruction
- `regfilemux_out_wb`  out  32  regfile write data

## Operation
- FSM states: IDLE, ACCESS, WB.
- IDLE or WB with `valid_ex=1`:
  - Latch `ctrl`, `funct3`, `rd`, `alu_out`, `br_en`, `rs2_out`, `u_imm`, `pc`.
  - If `data_read` or `data_write` is set, go to ACCESS. Otherwise go to WB.
- IDLE or WB with `valid_ex=0`: go to IDLE.
- ACCESS:
  - `data_read` or `data_write` is held high, with address, wdata and mbe stable, until `data_resp=1`.
  - On `data_resp=1`, capture `data_rdata` and go to WB.
- WB:
  - `load_regfile_wb = ctrl.load_regfile && rd != 0`. Writes to x0 are always suppressed.
  - A new instruction may be accepted in the same cycle.
- `regfilemux_out_wb` is selected by `regfilemux_sel`:
  - `alu_out` → `alu_out`
  - `br_en` → `{31'b0, br_en}`
  - `u_imm` → `u_imm`
  - `pc_plus4` → `pc + 4`
  - `lw` → `rdata`
  - `lb` / `lbu` → byte at `alu_out[1:0]`, sign- / zero-extended
  - `lh` / `lhu` → half at `alu_out[1]`, sign- / zero-extended
- Store encoding by `funct3`:
  - `sb`: mbe = `4'b0001 << addr[1:0]`, wdata = `rs2 << 8*addr[1:0]`
  - `sh`: mbe = `4'b0011 << {addr[1],1'b0}`, wdata = `rs2 << 16*addr[1]`
  - `sw`: mbe = `4'b1111`, wdata = `rs2`
- Misaligned accesses: low address bits beyond the access size are ignored (truncation). No trap is raised.
- `stall_mem = (state == ACCESS)`.
- `valid_ex` presented while in ACCESS is ignored; upstream holds it because `stall_mem` is high.
- `data_resp` received while not in ACCESS is ignored.

## Timing
- Reset (`rst=0` at an edge):
  - State goes to IDLE.
  - All outputs are 0: `data_addr`, `data_wdata`, `data_mbe`, `data_read`, `data_write`, `stall_mem`, `rd_wb`, `load_regfile_wb`, `regfilemux_out_wb`.
  - An outstanding memory request is dropped: strobes are low in the cycle after the reset edge.
- Non-memory instruction accepted at edge N: `load_regfile_wb` is high for exactly cycle N+1 (latency 1).
- Memory instruction accepted at edge N:
  - Strobes are registered and high from cycle N+1.
  - If `data_resp` is sampled at edge M, WB outputs are valid in cycle M+1.
  - `stall_mem` is high in cycles N+1..M. Minimum latency is 2 (resp in cycle N+1).
- Back-to-back: an instruction accepted during a WB cycle issues with no bubble.
- All outputs are registered. There are no combinational paths from `data_resp` or `valid_ex` to outputs.

## Structure
- `rv32i_types`:
  - Add `pc_plus4` to the `regfilemux` enum.
  - Add `mem_wb_state_t` {IDLE, ACCESS, WB}.
  - Reuse `load_funct3_t` and `store_funct3_t`.
- Sub-module `mem_align` (combinational):
  - Store side: (`funct3`, `addr[1:0]`, `rs2`) → (`mbe`, `wdata`).
  - Load side: (`sel`, `addr[1:0]`, `rdata`) → extended load value.

## Test plan
- `op_imm` add, rd=5, `alu_out=0x1234`, valid at edge 0 → cycle 1: `load_regfile_wb=1`, `rd_wb=5`, `regfilemux_out_wb=0x1234`; cycle 2: `load_regfile_wb=0`.
- `lb` rd=3, addr=0x1003, resp after 3 cycles with rdata=0x80FF_0000 → `stall_mem` high 3 cycles, `data_addr=0x1000`; then `regfilemux_out_wb=0xFFFF_FF80`. Same case with `lbu` → `0x0000_0080`.
- `sh` addr=0x2002, rs2=0xDEAD_BEEF → `data_mbe=4'b1100`, `data_wdata=0xBEEF_0000`, `data_write` held until resp; `load_regfile_wb` never asserted.
- `lui` rd=0, `u_imm=0xABCD_E000` → `load_regfile_wb=0`. `jal` rd=1, pc=0x60 → `regfilemux_out_wb=0x64`.
- `rst=0` while in ACCESS with resp pending → next cycle `data_read=0`, all outputs 0; a late `data_resp` is ignored.

Source files
------------

// File: rtl/regfilemux.sv
// rtl/regfilemux.sv - regfile write-data source selector encoding
package regfilemux;

    typedef enum logic [3:0] {
        alu_out  = 4'd0,
        br_en    = 4'd1,
        u_imm    = 4'd2,
        lw       = 4'd3,
        pc_plus4 = 4'd4,
        lb       = 4'd5,
        lbu      = 4'd6,
        lh       = 4'd7,
        lhu      = 4'd8
    } regfilemux_sel_t;

endpackage : regfilemux

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WB     = 2'd2
    } mem_wb_state_t;

    typedef struct packed {
        rv32i_opcode                 opcode;
        logic                        load_regfile;
        logic                        data_read;
        logic                        data_write;
        regfilemux::regfilemux_sel_t regfilemux_sel;
    } rv32i_control_word;

endpackage : rv32i_types

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane placement for stores and extraction/extension for loads
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0]                  store_funct3_i,
    input  logic [1:0]                  offset_i,
    input  logic [31:0]                 store_data_i,
    output logic [3:0]                  mbe_o,
    output logic [31:0]                 wdata_o,
    input  regfilemux::regfilemux_sel_t load_sel_i,
    input  logic [31:0]                 load_rdata_i,
    output logic [31:0]                 load_value_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Misaligned offsets are truncated to the access size rather than trapped.
    assign byte_v = load_rdata_i[{offset_i, 3'b000} +: 8];
    assign half_v = load_rdata_i[{offset_i[1], 4'b0000} +: 16];

    // Store side: move the low bytes of rs2 into the addressed lanes.
    always_comb begin
        mbe_o   = 4'b1111;
        wdata_o = store_data_i;
        case (store_funct3_t'(store_funct3_i))
            sb: begin
                mbe_o   = 4'b0001 << offset_i;
                wdata_o = store_data_i << {offset_i, 3'b000};
            end
            sh: begin
                mbe_o   = 4'b0011 << {offset_i[1], 1'b0};
                wdata_o = store_data_i << {offset_i[1], 4'b0000};
            end
            default: begin
                mbe_o   = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase
    end

    // Load side: pick the addressed lane and sign- or zero-extend it.
    always_comb begin
        load_value_o = load_rdata_i;
        case (load_sel_i)
            regfilemux::lb:  load_value_o = {{24{byte_v[7]}}, byte_v};
            regfilemux::lbu: load_value_o = {24'h0, byte_v};
            regfilemux::lh:  load_value_o = {{16{half_v[15]}}, half_v};
            regfilemux::lhu: load_value_o = {16'h0, half_v};
            default:         load_value_o = load_rdata_i;
        endcase
    end

endmodule : mem_align

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RV32I memory-access and writeback pipeline stage
module mem_wb_stage
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_ex,
    input  rv32i_control_word ctrl_ex,
    input  logic [2:0]        funct3_ex,
    input  logic [4:0]        rd_ex,
    input  logic [31:0]       alu_out_ex,
    input  logic              br_en_ex,
    input  logic [31:0]       rs2_out_ex,
    input  logic [31:0]       u_imm_ex,
    input  logic [31:0]       pc_ex,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    output logic [3:0]        data_mbe,
    output logic              data_read,
    output logic              data_write,
    input  logic [31:0]       data_rdata,
    input  logic              data_resp,
    output logic              stall_mem,
    output logic [4:0]        rd_wb,
    output logic              load_regfile_wb,
    output logic [31:0]       regfilemux_out_wb
);

    mem_wb_state_t               state_q, state_d;
    logic                        load_regfile_q, load_regfile_d;
    logic                        data_read_q, data_read_d;
    logic                        data_write_q, data_write_d;
    regfilemux::regfilemux_sel_t sel_q, sel_d;
    logic [2:0]                  funct3_q, funct3_d;
    logic [4:0]                  rd_q, rd_d;
    logic [31:0]                 alu_q, alu_d;
    logic                        br_q, br_d;
    logic [31:0]                 rs2_q, rs2_d;
    logic [31:0]                 uimm_q, uimm_d;
    logic [31:0]                 pc_q, pc_d;
    logic [31:0]                 rdata_q, rdata_d;

    logic [3:0]                  mbe_raw;
    logic [31:0]                 wdata_raw;
    logic [31:0]                 load_value;
    logic                        unused_opcode;

    // The opcode travels with the control word but this stage decodes only the flag bits.
    assign unused_opcode = ^ctrl_ex.opcode;

    // Next-state: accept from IDLE/WB, wait in ACCESS for the memory response.
    always_comb begin
        state_d        = state_q;
        load_regfile_d = load_regfile_q;
        data_read_d    = data_read_q;
        data_write_d   = data_write_q;
        sel_d          = sel_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        alu_d          = alu_q;
        br_d           = br_q;
        rs2_d          = rs2_q;
        uimm_d         = uimm_q;
        pc_d           = pc_q;
        rdata_d        = rdata_q;
        case (state_q)
            ACCESS: begin
                if (data_resp) begin
                    rdata_d = data_rdata;
                    state_d = WB;
                end
            end
            default: begin
                if (valid_ex) begin
                    load_regfile_d = ctrl_ex.load_regfile;
                    data_read_d    = ctrl_ex.data_read;
                    data_write_d   = ctrl_ex.data_write;
                    sel_d          = ctrl_ex.regfilemux_sel;
                    funct3_d       = funct3_ex;
                    rd_d           = rd_ex;
                    alu_d          = alu_out_ex;
                    br_d           = br_en_ex;
                    rs2_d          = rs2_out_ex;
                    uimm_d         = u_imm_ex;
                    pc_d           = pc_ex;
                    state_d        = (ctrl_ex.data_read || ctrl_ex.data_write) ? ACCESS : WB;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Pipeline registers; reset drops any outstanding memory request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            load_regfile_q <= 1'b0;
            data_read_q    <= 1'b0;
            data_write_q   <= 1'b0;
            sel_q          <= regfilemux::alu_out;
            funct3_q       <= 3'b000;
            rd_q           <= 5'd0;
            alu_q          <= 32'h0;
            br_q           <= 1'b0;
            rs2_q          <= 32'h0;
            uimm_q         <= 32'h0;
            pc_q           <= 32'h0;
            rdata_q        <= 32'h0;
        end else begin
            state_q        <= state_d;
            load_regfile_q <= load_regfile_d;
            data_read_q    <= data_read_d;
            data_write_q   <= data_write_d;
            sel_q          <= sel_d;
            funct3_q       <= funct3_d;
            rd_q           <= rd_d;
            alu_q          <= alu_d;
            br_q           <= br_d;
            rs2_q          <= rs2_d;
            uimm_q         <= uimm_d;
            pc_q           <= pc_d;
            rdata_q        <= rdata_d;
        end
    end

    mem_align u_align (
        .store_funct3_i (funct3_q),
        .offset_i       (alu_q[1:0]),
        .store_data_i   (rs2_q),
        .mbe_o          (mbe_raw),
        .wdata_o        (wdata_raw),
        .load_sel_i     (sel_q),
        .load_rdata_i   (rdata_q),
        .load_value_o   (load_value)
    );

    // Memory-side outputs come only from held registers, so they stay stable through ACCESS.
    assign data_addr  = {alu_q[31:2], 2'b00};
    assign data_mbe   = data_write_q ? mbe_raw : 4'b0000;
    assign data_wdata = data_write_q ? wdata_raw : 32'h0;
    assign data_read  = (state_q == ACCESS) && data_read_q;
    assign data_write = (state_q == ACCESS) && data_write_q;
    assign stall_mem  = (state_q == ACCESS);

    // Writeback: x0 writes are always suppressed.
    assign rd_wb           = rd_q;
    assign load_regfile_wb = (state_q == WB) && load_regfile_q && (rd_q != 5'd0);

    // Regfile write-data mux over the held instruction results.
    always_comb begin
        regfilemux_out_wb = alu_q;
        case (sel_q)
            regfilemux::alu_out:  regfilemux_out_wb = alu_q;
            regfilemux::br_en:    regfilemux_out_wb = {31'h0, br_q};
            regfilemux::u_imm:    regfilemux_out_wb = uimm_q;
            regfilemux::pc_plus4: regfilemux_out_wb = pc_q + 32'd4;
            default:              regfilemux_out_wb = load_value;
        endcase
    end

endmodule : mem_wb_stage
